// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multicycle MIPS control path:
//   - opcode constants for the supported instruction classes
//   - ALUOp, ALUSrcB and PCSource select encodings
//   - mc_state_t : 4-bit control FSM state encoding (also exported for debug)
//   - mc_ctrl_t  : bundle of every datapath control produced by the decoder
// ---------------------------------------------------------------------------
package mips_pkg;

    // IR[31:26] values of the supported instructions
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REG     = 2'b00;  // register B
    localparam logic [1:0] SRCB_FOUR    = 2'b01;  // constant 4
    localparam logic [1:0] SRCB_IMM     = 2'b10;  // sign-extended immediate
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;  // sign-extended immediate << 2

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_TRAP   = 4'd11
    } mc_state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       retire;
        logic       illegal_op;
    } mc_ctrl_t;

    // Every control deasserted; the value of any field a state does not set
    localparam mc_ctrl_t CTRL_IDLE = '0;

    // LW and SW share the address-calculation path
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
// Bundle between the control FSM and the multicycle datapath.
//   master : the control unit (consumes opcode/zero/mem_ready, drives controls)
//   slave  : the datapath/memory side (the mirror image)
// Signals:
//   opcode[5:0], zero, mem_ready          datapath/memory -> control
//   PCWrite .. ALUSrcA (1 bit each),
//   ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0],
//   retire, illegal_op, state[3:0]        control -> datapath / debug
// ---------------------------------------------------------------------------
interface multicycle_control_if;

    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       retire;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               retire, illegal_op, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               retire, illegal_op, state
    );

endinterface

// File: rtl/mc_output_decode.sv
// ---------------------------------------------------------------------------
// mc_output_decode
// Purely combinational decode of the control FSM state into every datapath
// control. Moore outputs, except the FETCH write enables and the MEMWR retire,
// which only assert on the cycle memory accepts the access.
// Ports:
//   i_state      current FSM state
//   i_mem_ready  memory completes its access this cycle
//   o_ctrl       all control outputs
// ---------------------------------------------------------------------------
module mc_output_decode
    import mips_pkg::*;
(
    input  mc_state_t i_state,
    input  logic      i_mem_ready,
    output mc_ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = CTRL_IDLE;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.ior_d     = 1'b0;
                o_ctrl.alu_src_a = 1'b0;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
                // Latch IR and advance PC only when the fetched word is valid
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                // Precompute the branch target while the opcode is decoded
                o_ctrl.alu_src_a = 1'b0;
                o_ctrl.alu_src_b = SRCB_IMM_SH2;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.ior_d    = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_dst    = 1'b0;
                o_ctrl.retire     = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.ior_d     = 1'b1;
                o_ctrl.mem_write = 1'b1;
                // A store completes only on the accepting cycle
                o_ctrl.retire    = i_mem_ready;
            end
            S_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REG;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = 1'b1;
                o_ctrl.mem_to_reg = 1'b0;
                o_ctrl.retire     = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_REG;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
                o_ctrl.retire        = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
                o_ctrl.retire    = 1'b1;
            end
            S_TRAP: begin
                o_ctrl.illegal_op = 1'b1;
            end
            // RESET and the unused encodings 12-15 drive nothing
            default: o_ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Main control FSM of the multicycle MIPS datapath. Sequences each instruction
// through fetch/decode/execute/memory/write-back in 3-5 cycles, stretching the
// memory states while mem_ready is low, and trapping unsupported opcodes.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  multicycle_control_if.master : opcode/zero/mem_ready in,
//        datapath controls, retire, illegal_op and debug state out
// ---------------------------------------------------------------------------
module multicycle_control
    import mips_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    multicycle_control_if.master       bus
);

    mc_state_t r_state;
    mc_state_t w_state_next;
    logic      r_rst_hold;
    mc_ctrl_t  w_ctrl;
    logic      w_unused_zero;

    // zero is consumed by the datapath through PCWriteCond, not by the FSM
    assign w_unused_zero = bus.zero;

    // Keeps the FSM in RESET for one full cycle after rst falls, so the first
    // fetch starts on the second rising edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_hold <= 1'b1;
        end else begin
            r_rst_hold <= 1'b0;
        end
    end

    always_comb begin
        w_state_next = S_FETCH;
        case (r_state)
            S_RESET:  w_state_next = r_rst_hold ? S_RESET : S_FETCH;
            S_FETCH:  w_state_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_mem_op(bus.opcode)) begin
                    w_state_next = S_MEMADR;
                end else if (bus.opcode == OP_RTYPE) begin
                    w_state_next = S_EXEC;
                end else if (bus.opcode == OP_BEQ) begin
                    w_state_next = S_BRANCH;
                end else if (bus.opcode == OP_J) begin
                    w_state_next = S_JUMP;
                end else begin
                    w_state_next = S_TRAP;
                end
            end
            // Only LW/SW reach here; anything not a store takes the load path
            S_MEMADR: w_state_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_state_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_state_next = S_FETCH;
            S_MEMWR:  w_state_next = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_state_next = S_RWB;
            S_RWB:    w_state_next = S_FETCH;
            S_BRANCH: w_state_next = S_FETCH;
            S_JUMP:   w_state_next = S_FETCH;
            // PC already advanced in FETCH, so resume at the next word
            S_TRAP:   w_state_next = S_FETCH;
            default:  w_state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    mc_output_decode u_output_decode (
        .i_state     (r_state),
        .i_mem_ready (bus.mem_ready),
        .o_ctrl      (w_ctrl)
    );

    assign bus.PCWrite     = w_ctrl.pc_write;
    assign bus.PCWriteCond = w_ctrl.pc_write_cond;
    assign bus.IorD        = w_ctrl.ior_d;
    assign bus.MemRead     = w_ctrl.mem_read;
    assign bus.MemWrite    = w_ctrl.mem_write;
    assign bus.MemtoReg    = w_ctrl.mem_to_reg;
    assign bus.IRWrite     = w_ctrl.ir_write;
    assign bus.RegWrite    = w_ctrl.reg_write;
    assign bus.RegDst      = w_ctrl.reg_dst;
    assign bus.ALUSrcA     = w_ctrl.alu_src_a;
    assign bus.ALUSrcB     = w_ctrl.alu_src_b;
    assign bus.ALUOp       = w_ctrl.alu_op;
    assign bus.PCSource    = w_ctrl.pc_source;
    assign bus.retire      = w_ctrl.retire;
    assign bus.illegal_op  = w_ctrl.illegal_op;
    assign bus.state       = r_state;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath variant. It sequences one instruction through fetch, decode, execute, memory and write-back over 3–5 cycles. It drives all datapath enables and muxes from a registered state. It stretches memory states on a `mem_ready` handshake, and flags unsupported opcodes.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  IR[31:26]; stable from DECODE onward.
- `zero`  in  1  ALU zero; consumed by datapath via `PCWriteCond`, unused internally.
- `mem_ready`  in  1  memory completes access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA`  out  1  datapath controls.
- `ALUSrcB`  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- `ALUOp`  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `retire`  out  1  one-cycle pulse on the last cycle of each legal instruction.
- `illegal_op`  out  1  one-cycle pulse in TRAP.
- `state`  out  4  current state, for debug.

## Operation
- Opcodes: R = 000000, LW = 100011, SW = 101011, BEQ = 000100, J = 000010. All other opcodes go to TRAP.
- The state register is 4 bits.
- Outputs are Moore decodes of `state`, except the FETCH and MEMWR enables noted below, which are gated by `mem_ready`.
- Any output not listed for a state is 0 in that state.

States (encoding, asserted outputs, next state):
- RESET (0): all outputs 0. Next: FETCH.
- FETCH (1): `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=00. `IRWrite`=`PCWrite`=`mem_ready`. Holds while `!mem_ready`; goes to DECODE on `mem_ready`.
- DECODE (2): `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00. Next by opcode: LW/SW → MEMADR, R → EXEC, BEQ → BRANCH, J → JUMP, else → TRAP.
- MEMADR (3): `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Next: LW → MEMRD, SW → MEMWR.
- MEMRD (4): `MemRead`=1, `IorD`=1. Holds until `mem_ready`, then MEMWB.
- MEMWB (5): `RegWrite`=1, `MemtoReg`=1, `RegDst`=0, `retire`=1. Next: FETCH.
- MEMWR (6): `IorD`=1, `MemWrite`=1, `retire`=`mem_ready`. Holds until `mem_ready`, then FETCH.
- EXEC (7): `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10. Next: RWB.
- RWB (8): `RegWrite`=1, `RegDst`=1, `MemtoReg`=0, `retire`=1. Next: FETCH.
- BRANCH (9): `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01, `retire`=1. Next: FETCH.
- JUMP (10): `PCWrite`=1, `PCSource`=10, `retire`=1. Next: FETCH.
- TRAP (11): `illegal_op`=1. Next: FETCH, so the PC has already advanced past the bad word.
- Encodings 12–15 are unreachable. They decode as RESET: all outputs 0, next state FETCH.

## Timing
- Reset:
  - `rst` high forces `state` = RESET asynchronously. All outputs are 0 while `rst` is high and in the first cycle after release.
  - FETCH begins at the 2nd rising edge after release.
- Zero-wait latencies (`mem_ready` tied high), in cycles from FETCH entry to next FETCH entry: LW 5, SW 4, R 4, BEQ 3, J 3, illegal 3.
- Each cycle `mem_ready` is low in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `MemRead` and `MemWrite` stay asserted, with stable `IorD`, until the accepting cycle.
- `PCWrite` and `IRWrite` never assert in FETCH without `mem_ready`.
- `opcode` is sampled only in DECODE and MEMADR.
- Reset mid-instruction: the instruction is abandoned with no further enables. No partial write-back is allowed after `rst` rises.
- `mem_ready` outside FETCH/MEMRD/MEMWR is ignored.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants: `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`;
  - ALUOp constants: `ALUOP_ADD`, `ALUOP_SUB`, `ALUOP_FUNCT`;
  - `ALUSrcB` and `PCSource` select constants;
  - the 4-bit state enum `mc_state_t`.
- One sub-module: `mc_output_decode`, purely combinational, taking (`state`, `mem_ready`) → all control outputs.
- The top level holds the state register and the next-state logic.

## Test plan
- Reset: hold `rst` high mid-EXEC, then release. Required: all outputs 0 immediately and one cycle after release; `state` = 1 on the 2nd edge.
- LW, `mem_ready`=1:
  - state sequence 1, 2, 3, 4, 5, 1;
  - `RegWrite`=`MemtoReg`=1 only in state 5;
  - `retire` pulses once.
- SW with `mem_ready` low for 2 cycles in MEMWR:
  - `MemWrite`=1 for 3 cycles with `IorD`=1;
  - `retire` only on the accept cycle;
  - 6 cycles in total.
- R-type, then BEQ, then J (000000, 000100, 000010):
  - 4, 3 and 3 cycles respectively;
  - BEQ shows `PCWriteCond`=1, `ALUOp`=01, `PCSource`=01;
  - J shows `PCWrite`=1, `PCSource`=10.
- Opcode 001000 (unsupported): sequence 1, 2, 11, 1; `illegal_op` pulses once; no `RegWrite`, `MemWrite` or `retire`.
- FETCH stall with `mem_ready`=0 for 3 cycles: `MemRead`=1 throughout; `PCWrite`=`IRWrite`=0 until the accept cycle, then 1 for exactly one cycle.
